// File: rtl/read_data_mc_fifo_pkg.sv
// Shared constants and types for the multi-channel read-data buffer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
`ifndef BACKEND_WORD_SIZE
`define BACKEND_WORD_SIZE 32
`endif

package read_data_mc_fifo_pkg;
  localparam int RDF_ADDR_BITS_DEF  = 4;
  localparam int RDF_NUM_CH_DEF     = 4;
  localparam int RDF_DATA_WIDTH_DEF = `BACKEND_WORD_SIZE;

  // One bit per channel (full/empty/stall/ovf/mask vectors).
  typedef logic [RDF_NUM_CH_DEF-1:0] rdf_ch_vec_t;
endpackage

// File: rtl/read_data_mc_fifo_ch_queue.sv
// One channel's circular queue: pointers, storage, flags, occupancy and stall hysteresis.
// Latency: a word written at edge N is the head (if queue was empty) from cycle N+1.
// Backpressure: caller must not assert wr_en when full; flags are registered from next-state pointers.
module read_data_ch_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_BITS:0]    stall_hi,
  input  logic [ADDR_BITS:0]    stall_lo,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  full,
  output logic                  empty,
  output logic                  stall,
  output logic [ADDR_BITS:0]    count
);
  localparam int CNT_W = ADDR_BITS + 1;
  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      wr_ptr_nxt, rd_ptr_nxt, cnt_nxt;
  logic                  full_nxt, empty_nxt, stall_nxt;

  // Next-state pointers; the extra top bit is the wrap bit distinguishing full from empty.
  always_comb begin
    wr_ptr_nxt = wr_ptr + CNT_W'(wr_en);
    rd_ptr_nxt = rd_ptr + CNT_W'(rd_en);
    cnt_nxt    = wr_ptr_nxt - rd_ptr_nxt;
    full_nxt   = (wr_ptr_nxt[ADDR_BITS-1:0] == rd_ptr_nxt[ADDR_BITS-1:0]) &&
                 (wr_ptr_nxt[ADDR_BITS] != rd_ptr_nxt[ADDR_BITS]);
    empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
    // Set threshold checked first so it dominates when lo >= hi.
    if (cnt_nxt >= stall_hi) begin
      stall_nxt = 1'b1;
    end else if (cnt_nxt <= stall_lo) begin
      stall_nxt = 1'b0;
    end else begin
      stall_nxt = stall;
    end
  end

  // Storage is not reset; only written words are ever presented.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_ptr[ADDR_BITS-1:0]] <= wr_data;
    end
  end

  // Pointer and status registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      stall  <= 1'b0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      full   <= full_nxt;
      empty  <= empty_nxt;
      stall  <= stall_nxt;
      count  <= cnt_nxt;
    end
  end

  assign head_data = mem[rd_ptr[ADDR_BITS-1:0]];
endmodule

// File: rtl/read_data_mc_fifo.sv
// Multi-channel read-data buffer: per-channel queues drained by a masked round-robin arbiter.
// Latency: 1 cycle write-to-output; 1 word/cycle sustained with i_rd_ready high.
// Backpressure: a presented word is locked (channel and data held) until i_rd_ready; writes to full channels drop and set o_ovf.
module read_data_mc_fifo
  import read_data_mc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = RDF_DATA_WIDTH_DEF,
  parameter int ADDR_BITS  = RDF_ADDR_BITS_DEF,
  parameter int NUM_CH     = RDF_NUM_CH_DEF,
  localparam int CH_BITS   = $clog2(NUM_CH),
  localparam int CNT_W     = ADDR_BITS + 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_wr_valid,
  input  logic [CH_BITS-1:0]      i_wr_ch,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic [CNT_W-1:0]        i_stall_hi,
  input  logic [CNT_W-1:0]        i_stall_lo,
  input  logic [NUM_CH-1:0]       i_ch_mask,
  input  logic                    i_ovf_clr,
  output logic                    o_rd_valid,
  output logic [CH_BITS-1:0]      o_rd_ch,
  output logic [DATA_WIDTH-1:0]   o_rd_data,
  input  logic                    i_rd_ready,
  output logic [NUM_CH-1:0]       o_full,
  output logic [NUM_CH-1:0]       o_empty,
  output logic [NUM_CH-1:0]       o_stall,
  output logic [NUM_CH-1:0]       o_ovf,
  output logic [NUM_CH*CNT_W-1:0] o_count
);
  logic [DATA_WIDTH-1:0] head [NUM_CH];
  logic [NUM_CH-1:0]     wr_req, ovf_set, rd_en, eligible;
  logic [CH_BITS-1:0]    rr_ptr, grant_ch, sel_ch, lock_ch, idx;
  logic                  any_elig, lock_q, xfer;

  // Write decode against registered full; out-of-range channels match nothing.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      wr_req[c]  = i_wr_valid && (i_wr_ch == CH_BITS'(c)) && !o_full[c];
      ovf_set[c] = i_wr_valid && (i_wr_ch == CH_BITS'(c)) &&  o_full[c];
      eligible[c] = !o_empty[c] && i_ch_mask[c];
      rd_en[c]   = xfer && (sel_ch == CH_BITS'(c));
    end
  end

  // Round-robin search upward from the channel after the last grant.
  always_comb begin
    any_elig = 1'b0;
    grant_ch = '0;
    idx      = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = CH_BITS'((int'(rr_ptr) + i) % NUM_CH);
      if (!any_elig && eligible[idx]) begin
        any_elig = 1'b1;
        grant_ch = idx;
      end
    end
  end

  assign sel_ch     = lock_q ? lock_ch : grant_ch;
  assign o_rd_valid = lock_q || any_elig;
  assign o_rd_ch    = sel_ch;
  assign o_rd_data  = head[sel_ch];
  assign xfer       = o_rd_valid && i_rd_ready;

  // Lock a stalled grant so the output stays stable; advance rr pointer on each transfer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lock_q  <= 1'b0;
      lock_ch <= '0;
      rr_ptr  <= CH_BITS'(NUM_CH - 1);
    end else if (xfer) begin
      lock_q  <= 1'b0;
      rr_ptr  <= sel_ch;
    end else if (o_rd_valid) begin
      lock_q  <= 1'b1;
      lock_ch <= sel_ch;
    end
  end

  // Sticky overflow; a fresh overflow beats a same-cycle clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ovf <= '0;
    end else begin
      o_ovf <= (i_ovf_clr ? '0 : o_ovf) | ovf_set;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    read_data_ch_queue #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_BITS (ADDR_BITS)
    ) u_queue (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .wr_en    (wr_req[c]),
      .wr_data  (i_wr_data),
      .rd_en    (rd_en[c]),
      .stall_hi (i_stall_hi),
      .stall_lo (i_stall_lo),
      .head_data(head[c]),
      .full     (o_full[c]),
      .empty    (o_empty[c]),
      .stall    (o_stall[c]),
      .count    (o_count[c*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_read_data_mc_fifo.sv
// Scoreboard bench: driver pushes expected words per channel, negedge monitor checks arbitration, data and status.
module tb_read_data_mc_fifo;
  import read_data_mc_fifo_pkg::*;

  localparam int DW = 32, AB = 4, NC = 4, CB = 2, CW = 5, DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wr_valid = 1'b0;
  logic [CB-1:0]   wr_ch = '0;
  logic [DW-1:0]   wr_data = '0;
  logic [CW-1:0]   stall_hi = '0, stall_lo = '0;
  rdf_ch_vec_t     ch_mask = '0;
  logic            ovf_clr = 1'b0;
  logic            rd_ready = 1'b0;
  logic            rd_valid;
  logic [CB-1:0]   rd_ch;
  logic [DW-1:0]   rd_data;
  logic [NC-1:0]   full, empty, stall, ovf;
  logic [NC*CW-1:0] count;

  read_data_mc_fifo #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .NUM_CH(NC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(wr_valid), .i_wr_ch(wr_ch),
    .i_wr_data(wr_data), .i_stall_hi(stall_hi), .i_stall_lo(stall_lo),
    .i_ch_mask(ch_mask), .i_ovf_clr(ovf_clr), .o_rd_valid(rd_valid),
    .o_rd_ch(rd_ch), .o_rd_data(rd_data), .i_rd_ready(rd_ready),
    .o_full(full), .o_empty(empty), .o_stall(stall), .o_ovf(ovf), .o_count(count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] d; int wc; } ent_t;
  ent_t q [NC][$];          // expected contents per channel; wc = edge at which it is written
  int   cyc = 0;
  int   checks = 0, errors = 0;
  logic [NC-1:0] ovf_m = '0, ovf_nxt = '0, stall_m = '0;
  int   rr_m = NC - 1, lock_ch_m = 0, hi_m = 0, lo_m = 0;
  bit   lock_m = 1'b0;

  always @(posedge clk) begin
    cyc   = cyc + 1;
    ovf_m = ovf_nxt;
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Occupancy the DUT should show now (excludes a word still waiting for its edge).
  function automatic int vis(int c);
    int n = q[c].size();
    if (n > 0 && q[c][n-1].wc > cyc) n--;
    return n;
  endfunction

  logic [NC-1:0]    elig_m, full_e, empty_e;
  logic [NC*CW-1:0] cnt_e;
  int               g, n_m, ix;
  bit               gv;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_empty", 64'(empty), 64'(4'hF));
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_valid", 64'(rd_valid), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_ovf",   64'(ovf), 64'd0);
      chk("rst_full",  64'(full), 64'd0);
    end else begin
      for (int c = 0; c < NC; c++) begin
        n_m = vis(c);
        cnt_e[c*CW +: CW] = CW'(n_m);
        full_e[c]  = (n_m == DEPTH);
        empty_e[c] = (n_m == 0);
        if (n_m >= hi_m) stall_m[c] = 1'b1;
        else if (n_m <= lo_m) stall_m[c] = 1'b0;
        elig_m[c] = (n_m > 0) && ch_mask[c];
      end
      gv = 1'b0; g = 0;
      if (lock_m) begin
        gv = 1'b1; g = lock_ch_m;
      end else begin
        for (int i = 1; i <= NC; i++) begin
          ix = (rr_m + i) % NC;
          if (!gv && elig_m[ix]) begin gv = 1'b1; g = ix; end
        end
      end
      chk("rd_valid", 64'(rd_valid), 64'(gv));
      if (gv) begin
        chk("rd_ch",   64'(rd_ch), 64'(g));
        chk("rd_data", 64'(rd_data), 64'(q[g][0].d));
      end
      chk("count", 64'(count), 64'(cnt_e));
      chk("full",  64'(full), 64'(full_e));
      chk("empty", 64'(empty), 64'(empty_e));
      chk("stall", 64'(stall), 64'(stall_m));
      chk("ovf",   64'(ovf), 64'(ovf_m));
      if (gv && rd_ready) begin
        q[g].delete(0);
        rr_m = g; lock_m = 1'b0;
      end else if (gv) begin
        lock_m = 1'b1; lock_ch_m = g;
      end
    end
  end

  // One cycle of stimulus; the expected word is queued when issued.
  task automatic drive(bit wv, int ch, logic [DW-1:0] d, logic [NC-1:0] m, bit rdy, bit clr);
    @(posedge clk); #1;
    wr_valid = wv; wr_ch = CB'(ch); wr_data = d; ch_mask = m; rd_ready = rdy; ovf_clr = clr;
    ovf_nxt = clr ? '0 : ovf_m;
    if (wv) begin
      if (q[ch].size() >= DEPTH) ovf_nxt[ch] = 1'b1;
      else q[ch].push_back('{d, cyc + 1});
    end
  endtask

  task automatic do_reset(int hi, int lo);
    @(posedge clk); #1;
    rst_n = 1'b0; wr_valid = 1'b0; ch_mask = '0; rd_ready = 1'b0; ovf_clr = 1'b0;
    stall_hi = CW'(hi); stall_lo = CW'(lo);
    for (int c = 0; c < NC; c++) q[c].delete();
    ovf_m = '0; ovf_nxt = '0; stall_m = '0; rr_m = NC - 1; lock_m = 1'b0;
    hi_m = hi; lo_m = lo;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic idle(int n, logic [NC-1:0] m, bit rdy);
    repeat (n) drive(1'b0, 0, '0, m, rdy, 1'b0);
  endtask

  initial begin
    do_reset(12, 4);
    // Overflow on ch2 while masked, then drain in order.
    for (int i = 0; i < 17; i++) drive(1'b1, 2, DW'(32'h100 + i), 4'h0, 1'b0, 1'b0);
    idle(2, 4'h0, 1'b0);
    idle(20, 4'hF, 1'b1);
    // Hysteresis on ch1.
    for (int i = 0; i < 12; i++) drive(1'b1, 1, DW'(32'h200 + i), 4'h0, 1'b0, 1'b0);
    idle(2, 4'h0, 1'b0);
    idle(14, 4'b0010, 1'b1);
    // Round robin over ch0/1/3, then with ch1 masked.
    for (int r = 0; r < 2; r++) begin
      do_reset(16, 0);
      for (int k = 0; k < 2; k++) begin
        drive(1'b1, 0, DW'(32'h300 + k), 4'h0, 1'b0, 1'b0);
        drive(1'b1, 1, DW'(32'h310 + k), 4'h0, 1'b0, 1'b0);
        drive(1'b1, 3, DW'(32'h330 + k), 4'h0, 1'b0, 1'b0);
      end
      idle(8, (r == 0) ? 4'hF : 4'b1101, 1'b1);
      idle(4, 4'hF, 1'b1);
    end
    // Backpressure: ch3 presented and held while a ch0 word arrives.
    drive(1'b1, 3, 32'hAAA3, 4'hF, 1'b0, 1'b0);
    idle(2, 4'hF, 1'b0);
    drive(1'b1, 0, 32'hAAA0, 4'h0, 1'b0, 1'b0);
    idle(2, 4'hF, 1'b0);
    idle(4, 4'hF, 1'b1);
    // Same-cycle write+read on full ch0, then on ch0 at count 5.
    do_reset(16, 0);
    for (int i = 0; i < 16; i++) drive(1'b1, 0, DW'(32'h400 + i), 4'h0, 1'b0, 1'b0);
    drive(1'b1, 0, 32'hDEAD, 4'h1, 1'b1, 1'b0);
    idle(10, 4'h1, 1'b1);
    drive(1'b1, 0, 32'hBEEF, 4'h1, 1'b1, 1'b0);
    idle(2, 4'h0, 1'b0);
    // Overflow beats clear, then clear alone.
    for (int i = 0; i < 16; i++) drive(1'b1, 2, DW'(32'h500 + i), 4'h0, 1'b0, 1'b0);
    drive(1'b1, 2, 32'h5FF, 4'h0, 1'b0, 1'b1);
    idle(1, 4'h0, 1'b0);
    drive(1'b0, 0, '0, 4'h0, 1'b0, 1'b1);
    idle(1, 4'h0, 1'b0);
    // Randomized traffic with a mid-traffic reset.
    for (int p = 0; p < 2; p++) begin
      do_reset($urandom_range(0, 16), $urandom_range(0, 16));
      for (int i = 0; i < 1500; i++) begin
        drive(($urandom_range(0, 9) < 7), $urandom_range(0, NC - 1), DW'($urandom),
              NC'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
      end
    end
    idle(2, 4'h0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/read_data_mc_fifo.md
# read_data_mc_fifo

Multi-channel read-data buffer between the DRAM backend and the frontend read-return path. It holds one independent circular queue per channel (bank or requester) and accepts at most one backend word per cycle, tagged with its channel. A per-channel stall signal with programmable hysteresis throttles issue. Stored words drain through a single valid/ready output port under round-robin arbitration with per-channel masking.

## Interface
- DATA_WIDTH, `BACKEND_WORD_SIZE, word width
- ADDR_BITS, 4, log2 of per-channel depth (depth 16)
- NUM_CH, 4, channel count (≥2); localparam CH_BITS = $clog2(NUM_CH), CNT_W = ADDR_BITS+1
- Reset is i_rst_n, asynchronous, active-low; clock is i_clk.
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_wr_valid  in  1  backend word present
- i_wr_ch  in  CH_BITS  target channel
- i_wr_data  in  DATA_WIDTH  word
- i_stall_hi  in  CNT_W  stall-assert threshold
- i_stall_lo  in  CNT_W  stall-release threshold
- i_ch_mask  in  NUM_CH  1 = channel eligible for output
- i_ovf_clr  in  1  clears o_ovf
- o_rd_valid  out  1  output word valid
- o_rd_ch  out  CH_BITS  channel of output word
- o_rd_data  out  DATA_WIDTH  output word
- i_rd_ready  in  1  consumer accepts
- o_full, o_empty, o_stall, o_ovf  out  NUM_CH each  per-channel status
- o_count  out  NUM_CH*CNT_W  per-channel occupancy; channel c at [c*CNT_W +: CNT_W]

## Operation
- Per channel: rd/wr pointers CNT_W wide with wrap bit. Full = same index, differing wrap bit. Empty = pointers equal.
- Write: wr_req[c] = i_wr_valid && i_wr_ch==c && !o_full[c], with o_full the registered value. A write to a full channel is dropped and sets o_ovf[c], which is sticky. This holds even if the same channel is read in that cycle.
- i_wr_ch ≥ NUM_CH: the write is dropped and no o_ovf bit is set.
- Read: a transfer happens when o_rd_valid && i_rd_ready. It pops the head of channel o_rd_ch.
- Simultaneous write and read on the same non-full channel: both occur; count unchanged.
- Arbitration: eligible[c] = !o_empty[c] && i_ch_mask[c]. rr_ptr holds the last granted channel, reset NUM_CH-1. Grant goes to the first eligible channel searching upward from rr_ptr+1 with wrap. On each transfer, rr_ptr takes the granted channel.
- Lock: when o_rd_valid && !i_rd_ready, the grant is latched (lock_q, lock_ch). While locked:
  - o_rd_valid, o_rd_ch and o_rd_data are held until the handshake.
  - Mask changes and newly eligible channels are ignored.
  - The lock releases on the transfer.
- o_rd_data is combinational from the granted channel's head entry. o_rd_valid = any eligible, or lock_q.
- Stall hysteresis per channel, on next occupancy n:
  - n ≥ i_stall_hi sets o_stall[c].
  - else n ≤ i_stall_lo clears it.
  - else o_stall[c] holds.
  - If lo ≥ hi, set wins.
- o_ovf: i_ovf_clr clears all bits. A new overflow in the same cycle wins over the clear.

## Timing
- Reset values (async): all pointers 0, o_empty all 1, o_full 0, o_stall 0, o_ovf 0, o_count 0, lock_q 0, rr_ptr NUM_CH-1, o_rd_valid 0. Memory is not reset.
- o_full, o_empty, o_stall and o_count are registered from next-state pointers. They reflect a write or read on the edge where it occurs.
- Write-to-output latency is 1 cycle. Word written at edge N → o_rd_valid high in cycle N+1 (if masked in and granted).
- Back-to-back output at 1 word/cycle with i_rd_ready held high. Consecutive words alternate channels when several are eligible.
- Pointer wrap: after 2^ADDR_BITS pushes and pops, the index returns to 0 and the wrap bit toggles.
- Reset asserted mid-transfer: all state clears immediately. In-flight data is discarded.

## Structure
- Add to userType_pkg:
  - localparam RDF_ADDR_BITS_DEF = 4
  - localparam RDF_NUM_CH_DEF = 4
  - a typedef for per-channel status vectors
- Sub-module read_data_ch_queue, instantiated NUM_CH times via generate. It contains pointers, memory, flags, count and stall hysteresis.
- The top level contains write decode, the round-robin arbiter, lock registers, the output mux and o_ovf.

## Test plan
- Reset check: assert i_rst_n low mid-traffic → next cycle o_empty=4'hF, o_count=0, o_rd_valid=0, o_stall=0, o_ovf=0.
- Overflow: write 17 words (0x100..0x110) to ch2, i_ch_mask=0 → o_full[2]=1, count 16, o_ovf[2]=1. Then unmask → words 0x100..0x10F read out in order and 0x110 is never seen.
- Hysteresis: hi=12, lo=4 on ch1; fill to 12 → stall rises with the 12th write. Drain to 5 → stall stays 1. Drain to 4 → stall falls.
- Round robin: ch0, ch1 and ch3 each hold 2 words, i_rd_ready=1 → o_rd_ch sequence 0,1,3,0,1,3. With i_ch_mask[1]=0 → 0,3,0,3.
- Backpressure: i_rd_ready=0 for 5 cycles while o_rd_valid=1 on ch3, then write ch0 → o_rd_ch and o_rd_data stay constant. ch3 transfers first when ready rises.
- Simultaneous events: ch0 at count 16 with a same-cycle write and read → count 15, write dropped, o_ovf[0]=1. ch0 at count 5 with both → count stays 5.
